// File: rtl/pipe_id_decode.sv
// ID-stage decoder feeding a registered ID/EX pipeline register for a MIPS-like core.
// Define PIPE_ID_LOAD_USE_EN to build in the load-use interlock (stall_req); otherwise hazards are handled outside.
module pipe_id_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        ivalid,
  input  logic        stall,
  input  logic        flush,
  output logic        stall_req,
  output logic [3:0]  ealuc,
  output logic        ealuimm,
  output logic        eshift,
  output logic        esext,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic [4:0]  ern,
  output logic        ejal,
  output logic        evalid,
  output logic        eillegal
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_BUBBLE = 2'd1,
    SEL_DECODE = 2'd2
  } sel_e;

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [5:0] w_funct;

  assign w_op    = inst[31:26];
  assign w_rt    = inst[20:16];
  assign w_rd    = inst[15:11];
  assign w_funct = inst[5:0];

  logic [3:0] w_d_aluc;
  logic       w_d_aluimm;
  logic       w_d_shift;
  logic       w_d_sext;
  logic       w_d_wreg;
  logic       w_d_m2reg;
  logic       w_d_wmem;
  logic [4:0] w_d_rn;
  logic       w_d_jal;
  logic       w_d_illegal;

  logic [3:0] r_ealuc;
  logic       r_ealuimm;
  logic       r_eshift;
  logic       r_esext;
  logic       r_ewreg;
  logic       r_em2reg;
  logic       r_ewmem;
  logic [4:0] r_ern;
  logic       r_ejal;
  logic       r_evalid;
  logic       r_eillegal;

  logic [3:0] w_n_ealuc;
  logic       w_n_ealuimm;
  logic       w_n_eshift;
  logic       w_n_esext;
  logic       w_n_ewreg;
  logic       w_n_em2reg;
  logic       w_n_ewmem;
  logic [4:0] w_n_ern;
  logic       w_n_ejal;
  logic       w_n_evalid;
  logic       w_n_eillegal;

  logic       w_load_use;
  sel_e       w_sel;

  // Unrecognised op/funct decodes to a write-free illegal slot with ern cleared.
  always_comb begin
    w_d_aluc    = ALU_ADD;
    w_d_aluimm  = 1'b0;
    w_d_shift   = 1'b0;
    w_d_sext    = 1'b0;
    w_d_wreg    = 1'b0;
    w_d_m2reg   = 1'b0;
    w_d_wmem    = 1'b0;
    w_d_rn      = w_rt;
    w_d_jal     = 1'b0;
    w_d_illegal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_d_rn = w_rd;
        case (w_funct)
          FN_ADD: begin w_d_aluc = ALU_ADD; w_d_wreg = 1'b1; end
          FN_SUB: begin w_d_aluc = ALU_SUB; w_d_wreg = 1'b1; end
          FN_AND: begin w_d_aluc = ALU_AND; w_d_wreg = 1'b1; end
          FN_OR:  begin w_d_aluc = ALU_OR;  w_d_wreg = 1'b1; end
          FN_XOR: begin w_d_aluc = ALU_XOR; w_d_wreg = 1'b1; end
          FN_SLL: begin w_d_aluc = ALU_SLL; w_d_wreg = 1'b1; w_d_shift = 1'b1; end
          FN_SRL: begin w_d_aluc = ALU_SRL; w_d_wreg = 1'b1; w_d_shift = 1'b1; end
          FN_SRA: begin w_d_aluc = ALU_SRA; w_d_wreg = 1'b1; w_d_shift = 1'b1; end
          FN_JR:  begin w_d_wreg = 1'b0; end
          default: begin
            w_d_illegal = 1'b1;
            w_d_rn      = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin w_d_aluimm = 1'b1; w_d_sext = 1'b1; w_d_wreg = 1'b1; end
      OP_ANDI: begin w_d_aluc = ALU_AND; w_d_aluimm = 1'b1; w_d_wreg = 1'b1; end
      OP_ORI:  begin w_d_aluc = ALU_OR;  w_d_aluimm = 1'b1; w_d_wreg = 1'b1; end
      OP_XORI: begin w_d_aluc = ALU_XOR; w_d_aluimm = 1'b1; w_d_wreg = 1'b1; end
      OP_LUI:  begin w_d_aluc = ALU_LUI; w_d_aluimm = 1'b1; w_d_wreg = 1'b1; end
      OP_LW: begin
        w_d_aluimm = 1'b1;
        w_d_sext   = 1'b1;
        w_d_wreg   = 1'b1;
        w_d_m2reg  = 1'b1;
      end
      OP_SW:  begin w_d_aluimm = 1'b1; w_d_sext = 1'b1; w_d_wmem = 1'b1; end
      OP_BEQ: begin w_d_aluc = ALU_SUB; w_d_sext = 1'b1; end
      OP_BNE: begin w_d_aluc = ALU_SUB; w_d_sext = 1'b1; end
      OP_J:   begin w_d_wreg = 1'b0; end
      OP_JAL: begin w_d_wreg = 1'b1; w_d_jal = 1'b1; w_d_rn = 5'd31; end
      default: begin
        w_d_illegal = 1'b1;
        w_d_rn      = 5'd0;
      end
    endcase
  end

`ifdef PIPE_ID_LOAD_USE_EN
  logic [4:0] w_rs;
  logic       w_use_rs;
  logic       w_use_rt;
  logic       w_unused;

  assign w_rs     = inst[25:21];
  assign w_unused = ^inst[10:6];

  // Which source registers the incoming instruction actually reads.
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: begin w_use_rs = 1'b1; w_use_rt = 1'b1; end
          FN_SLL, FN_SRL, FN_SRA: begin w_use_rt = 1'b1; end
          FN_JR: begin w_use_rs = 1'b1; end
          default: begin w_use_rs = 1'b0; w_use_rt = 1'b0; end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin w_use_rs = 1'b1; end
      OP_SW, OP_BEQ, OP_BNE: begin w_use_rs = 1'b1; w_use_rt = 1'b1; end
      default: begin w_use_rs = 1'b0; w_use_rt = 1'b0; end
    endcase
  end

  assign w_load_use = r_evalid & r_em2reg & (r_ern != 5'd0) & ivalid &
                      ((w_use_rs & (w_rs == r_ern)) | (w_use_rt & (w_rt == r_ern)));
  assign stall_req  = w_load_use & ~stall;
`else
  logic w_unused;

  assign w_unused   = ^{inst[25:21], inst[10:6]};
  assign w_load_use = 1'b0;
  assign stall_req  = 1'b0;
`endif

  // Flush beats stall, so flush+stall yields a bubble rather than a hold.
  always_comb begin
    w_sel = SEL_BUBBLE;
    if (flush) begin
      w_sel = SEL_BUBBLE;
    end else if (stall) begin
      w_sel = SEL_HOLD;
    end else if (w_load_use) begin
      w_sel = SEL_BUBBLE;
    end else if (ivalid) begin
      w_sel = SEL_DECODE;
    end else begin
      w_sel = SEL_BUBBLE;
    end
  end

  // Next ID/EX contents: hold, fresh decode, or all-zero bubble.
  always_comb begin
    w_n_ealuc    = r_ealuc;
    w_n_ealuimm  = r_ealuimm;
    w_n_eshift   = r_eshift;
    w_n_esext    = r_esext;
    w_n_ewreg    = r_ewreg;
    w_n_em2reg   = r_em2reg;
    w_n_ewmem    = r_ewmem;
    w_n_ern      = r_ern;
    w_n_ejal     = r_ejal;
    w_n_evalid   = r_evalid;
    w_n_eillegal = r_eillegal;
    case (w_sel)
      SEL_HOLD: begin
        w_n_evalid = r_evalid;
      end
      SEL_DECODE: begin
        w_n_ealuc    = w_d_aluc;
        w_n_ealuimm  = w_d_aluimm;
        w_n_eshift   = w_d_shift;
        w_n_esext    = w_d_sext;
        w_n_ewreg    = w_d_wreg;
        w_n_em2reg   = w_d_m2reg;
        w_n_ewmem    = w_d_wmem;
        w_n_ern      = w_d_rn;
        w_n_ejal     = w_d_jal;
        w_n_evalid   = 1'b1;
        w_n_eillegal = w_d_illegal;
      end
      default: begin
        w_n_ealuc    = 4'b0000;
        w_n_ealuimm  = 1'b0;
        w_n_eshift   = 1'b0;
        w_n_esext    = 1'b0;
        w_n_ewreg    = 1'b0;
        w_n_em2reg   = 1'b0;
        w_n_ewmem    = 1'b0;
        w_n_ern      = 5'd0;
        w_n_ejal     = 1'b0;
        w_n_evalid   = 1'b0;
        w_n_eillegal = 1'b0;
      end
    endcase
  end

  // ID/EX register; asynchronous reset clears it to a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ealuc    <= 4'b0000;
      r_ealuimm  <= 1'b0;
      r_eshift   <= 1'b0;
      r_esext    <= 1'b0;
      r_ewreg    <= 1'b0;
      r_em2reg   <= 1'b0;
      r_ewmem    <= 1'b0;
      r_ern      <= 5'd0;
      r_ejal     <= 1'b0;
      r_evalid   <= 1'b0;
      r_eillegal <= 1'b0;
    end else begin
      r_ealuc    <= w_n_ealuc;
      r_ealuimm  <= w_n_ealuimm;
      r_eshift   <= w_n_eshift;
      r_esext    <= w_n_esext;
      r_ewreg    <= w_n_ewreg;
      r_em2reg   <= w_n_em2reg;
      r_ewmem    <= w_n_ewmem;
      r_ern      <= w_n_ern;
      r_ejal     <= w_n_ejal;
      r_evalid   <= w_n_evalid;
      r_eillegal <= w_n_eillegal;
    end
  end

  assign ealuc    = r_ealuc;
  assign ealuimm  = r_ealuimm;
  assign eshift   = r_eshift;
  assign esext    = r_esext;
  assign ewreg    = r_ewreg;
  assign em2reg   = r_em2reg;
  assign ewmem    = r_ewmem;
  assign ern      = r_ern;
  assign ejal     = r_ejal;
  assign evalid   = r_evalid;
  assign eillegal = r_eillegal;

endmodule

// File: tb/tb_pipe_id_decode.sv
// Directed, table-driven bench for pipe_id_decode; interlock expectations follow PIPE_ID_LOAD_USE_EN.
module tb_pipe_id_decode;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic        ivalid;
  logic        stall;
  logic        flush;
  logic        stall_req;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift, esext, ewreg, em2reg, ewmem, ejal, evalid, eillegal;
  logic [4:0]  ern;

  int checks = 0;
  int errors = 0;

  pipe_id_decode dut (
    .clock(clk), .reset(reset), .inst(inst), .ivalid(ivalid), .stall(stall), .flush(flush),
    .stall_req(stall_req), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .esext(esext),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern), .ejal(ejal), .evalid(evalid),
    .eillegal(eillegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: {aluc, aluimm, shift, sext, wreg, m2reg, wmem, rn, jal, valid, illegal}
  function automatic logic [17:0] mk(input logic [3:0] a, input logic im, input logic sh,
                                     input logic sx, input logic wr, input logic m2,
                                     input logic wm, input logic [4:0] rn, input logic jl,
                                     input logic vl, input logic il);
    return {a, im, sh, sx, wr, m2, wm, rn, jl, vl, il};
  endfunction

  logic [17:0] obs;
  assign obs = {ealuc, ealuimm, eshift, esext, ewreg, em2reg, ewmem, ern, ejal, evalid, eillegal};

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        ivalid;
    logic [17:0] exp;
    string       name;
  } vec_t;

  vec_t vt[19];
  localparam logic [17:0] BUBBLE = 18'd0;
  logic [17:0] add5_exp;
  logic [17:0] add3_exp;
  logic [17:0] lw_exp;

  initial begin
    vt[0]  = '{32'h00221820, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd3, 1'b0,1'b1,1'b0), "add"};
    vt[1]  = '{32'h00031103, 1'b1, mk(4'b1111,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd2, 1'b0,1'b1,1'b0), "sra"};
    vt[2]  = '{32'h3C071234, 1'b1, mk(4'b0110,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd7, 1'b0,1'b1,1'b0), "lui"};
    vt[3]  = '{32'h8C240008, 1'b1, mk(4'b0000,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd4, 1'b0,1'b1,1'b0), "lw"};
    vt[4]  = '{32'hAC450004, 1'b1, mk(4'b0000,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,5'd5, 1'b0,1'b1,1'b0), "sw"};
    vt[5]  = '{32'h10220003, 1'b1, mk(4'b0100,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd2, 1'b0,1'b1,1'b0), "beq"};
    vt[6]  = '{32'h0C000010, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd31,1'b1,1'b1,1'b0), "jal"};
    vt[7]  = '{32'h08000010, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0), "j"};
    vt[8]  = '{32'hFC000000, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b1), "illegal_op"};
    vt[9]  = '{32'h342600FF, 1'b1, mk(4'b0101,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd6, 1'b0,1'b1,1'b0), "ori"};
    vt[10] = '{32'h012A4022, 1'b1, mk(4'b0100,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd8, 1'b0,1'b1,1'b0), "sub"};
    vt[11] = '{32'h000C5882, 1'b1, mk(4'b0111,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd11,1'b0,1'b1,1'b0), "srl"};
    vt[12] = '{32'h03E00008, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0), "jr"};
    vt[13] = '{32'h0000003F, 1'b1, mk(4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b1), "illegal_funct"};
    vt[14] = '{32'h00221820, 1'b0, BUBBLE, "ivalid_low"};
    vt[15] = '{32'h39CD0001, 1'b1, mk(4'b0010,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd13,1'b0,1'b1,1'b0), "xori"};
    vt[16] = '{32'h2041FFFF, 1'b1, mk(4'b0000,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd1, 1'b0,1'b1,1'b0), "addi"};
    vt[17] = '{32'h00851824, 1'b1, mk(4'b0001,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd3, 1'b0,1'b1,1'b0), "and"};
    vt[18] = '{32'h000208C0, 1'b1, mk(4'b0011,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd1, 1'b0,1'b1,1'b0), "sll"};
    add5_exp = mk(4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd5,1'b0,1'b1,1'b0);
    add3_exp = vt[0].exp;
    lw_exp   = vt[3].exp;

    reset = 1'b1; inst = 32'd0; ivalid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("reset_outputs", obs, BUBBLE);
    chk("reset_stall_req", {17'd0, stall_req}, 18'd0);
    #10;
    reset = 1'b0;

    // First entry also covers the first edge after reset release.
    for (int i = 0; i < 19; i++) begin
      inst = vt[i].inst; ivalid = vt[i].ivalid;
      tick();
      chk(vt[i].name, obs, vt[i].exp);
    end
    ivalid = 1'b0;
    tick();

    // Hold for three cycles, then flush together with stall gives a bubble.
    inst = 32'h00221820; ivalid = 1'b1;
    tick();
    chk("hold_setup", obs, add3_exp);
    inst = 32'h3C071234; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", obs, add3_exp);
    end
    flush = 1'b1;
    tick();
    chk("flush_with_stall", obs, BUBBLE);
    stall = 1'b0;
    inst = 32'h00221820;
    tick();
    chk("flush_alone", obs, BUBBLE);
    flush = 1'b0;
    tick();
    chk("after_flush", obs, add3_exp);

    // Load-use sequence.
    inst = 32'h8C240008; ivalid = 1'b1;
    tick();
    chk("lu_lw", obs, lw_exp);
    inst = 32'h00842820;
    #1;
`ifdef PIPE_ID_LOAD_USE_EN
    chk("lu_stall_req_high", {17'd0, stall_req}, 18'd1);
    tick();
    chk("lu_bubble", obs, BUBBLE);
    chk("lu_stall_req_clear", {17'd0, stall_req}, 18'd0);
    tick();
    chk("lu_add_issue", obs, add5_exp);
    // stall masks the request; reset mid-interlock drops the pending bubble.
    inst = 32'h8C240008;
    tick();
    inst = 32'h00842820; stall = 1'b1;
    #1;
    chk("lu_masked_by_stall", {17'd0, stall_req}, 18'd0);
    stall = 1'b0;
    #1;
    chk("lu_req_again", {17'd0, stall_req}, 18'd1);
    reset = 1'b1;
    #1;
    chk("lu_reset_outputs", obs, BUBBLE);
    chk("lu_reset_stall_req", {17'd0, stall_req}, 18'd0);
    reset = 1'b0;
    tick();
    chk("lu_after_reset_load", obs, add5_exp);
`else
    chk("lu_stall_req_tied", {17'd0, stall_req}, 18'd0);
    tick();
    chk("lu_add_immediate", obs, add5_exp);
`endif

    // Asynchronous reset between edges while ewreg=1.
    inst = 32'h00221820; ivalid = 1'b1;
    tick();
    chk("async_setup", obs, add3_exp);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", obs, BUBBLE);
    #1;
    reset = 1'b0;
    ivalid = 1'b0;
    tick();
    chk("idle_after_reset", obs, BUBBLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_id_decode.md
PIPE_ID_DECODE -- requirements
Module: pipe_id_decode

Interface
REQ-001 The block SHALL have these ports: clock in 1, rising-edge clock; reset in 1, active-high asynchronous reset; inst in 32, ID-stage instruction word; ivalid in 1, inst is valid; stall in 1, freeze ID/EX register; flush in 1, replace ID/EX contents with a bubble.
REQ-002 The block SHALL also drive stall_req out 1, load-use interlock request (combinational).
REQ-003 The block SHALL register these outputs: ealuc out 4, EX ALU control; ealuimm out 1, operand b is the immediate; eshift out 1, operand a is the shamt; esext out 1, sign-extend the immediate; ewreg out 1, register write; em2reg out 1, write-back from memory; ewmem out 1, memory write; ern out 5, destination register; ejal out 1, link write; evalid out 1, EX slot valid; eillegal out 1, undecodable opcode.

Function
REQ-004 ealuc encoding SHALL be add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111, with bit 3 zero for all non-sra codes.
REQ-005 R-type (op 000000) decode SHALL cover funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000000 sll, 000010 srl, 000011 sra, 001000 jr; ern=rd; eshift=1 only for sll/srl/sra; ewreg=0 for jr.
REQ-006 I-type decode SHALL cover addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011; ern=rt; ealuimm=1 for addi/andi/ori/xori/lui/lw/sw; esext=1 for addi/lw/sw/beq/bne.
REQ-007 lw SHALL set ewreg=1, em2reg=1, ealuc=add; sw SHALL set ewmem=1, ewreg=0, ealuc=add; beq/bne SHALL set ealuc=sub, no writes; j SHALL set no writes; jal SHALL set ewreg=1, ejal=1, ern=31.
REQ-008 Any other op/funct SHALL set eillegal=1 and force ewreg=ewmem=em2reg=0, with evalid=ivalid.
REQ-009 Latency SHALL be exactly one clock: decode of inst at edge N appears on the e* outputs after edge N.
REQ-010 A bubble SHALL mean every e* output is 0.
REQ-011 Per-edge priority SHALL be: reset > flush (load bubble) > stall (hold all e* outputs) > load-use (load bubble) > ivalid=1 (load decode) > ivalid=0 (load bubble).
REQ-012 Simultaneous flush and stall SHALL produce a bubble, not a hold.
REQ-013 The load-use condition SHALL be evalid & em2reg & ern!=0 & ivalid & (ern equals an rs or rt the incoming inst reads).
REQ-014 Source-register usage for REQ-013 SHALL be: R-type ALU reads rs,rt; shifts read rt only; jr reads rs; I-type ALU and lw read rs; sw/beq/bne read rs,rt; lui/j/jal/illegal read none.
REQ-015 stall_req SHALL equal the load-use condition ANDed with !stall; the upstream stage holds inst while stall_req=1, and the interlock clears after one bubble.
REQ-016 stall_req SHALL NOT depend on flush.

Reset
REQ-017 On reset assertion, all e* outputs SHALL go to 0 immediately, without waiting for a clock.
REQ-018 After reset, stall_req SHALL be 0 because evalid=0.
REQ-019 Reset mid-interlock SHALL drop the pending bubble.
REQ-020 The first edge after reset release SHALL load normally.

Configuration
REQ-021 Macro PIPE_ID_LOAD_USE_EN SHALL control the interlock: defined, REQ-013..REQ-016 apply; undefined, stall_req is tied 0, the load-use term is removed from REQ-011, and hazards are handled externally.

Verification
REQ-022 inst=0x00221820 (add $3,$1,$2), ivalid=1 -> next cycle ealuc=0000, ewreg=1, ern=3, ealuimm=0, evalid=1.
REQ-023 inst=0x00031103 (sra $2,$3,4) -> ealuc=1111, eshift=1, ern=2; inst=0x3C071234 (lui $7) -> ealuc=0110, ealuimm=1, esext=0, ern=7.
REQ-024 Interlock: 0x8C240008 (lw $4,8($1)), then 0x00842820 (add $5,$4,$4) -> stall_req=1 for one cycle, one bubble (evalid=0), then the add issues with ern=5 (macro defined); with the macro undefined, stall_req stays 0 and the add issues immediately.
REQ-025 inst=0xFC000000 -> eillegal=1, ewreg=0, ewmem=0, evalid=1.
REQ-026 Hold then bubble: stall=1 for 3 cycles after an add -> outputs unchanged; flush=1 together with stall=1 -> bubble next edge.
REQ-027 Async reset: assert reset between edges while ewreg=1 -> all outputs 0 before the next edge.
